// File: rtl/image_overlay_reader.sv
// Upscaled 28x28 image-memory overlay with a 1-pixel frame on the live VGA pixel stream.
// Fixed 3-cycle latency for every pixel; addressing uses only counters and accumulators.
module image_overlay_reader #(
   parameter int unsigned X0          = 400,
   parameter int unsigned Y0          = 16,
   parameter int unsigned SCALE_LOG2  = 3,
   parameter int unsigned IMG_DIM     = 28,
   parameter logic [7:0]  BORDER_GRAY = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ovl_en,
   input  logic       pix_de,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic [7:0] pix_in,
   output logic [9:0] mem_raddr,
   input  logic [7:0] mem_rdata,
   output logic [7:0] pix_out,
   output logic       pix_out_de,
   output logic       frame_done
);

   localparam int unsigned W     = IMG_DIM << SCALE_LOG2;
   localparam int unsigned SubW  = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
   localparam int unsigned IdxW  = $clog2(IMG_DIM);
   localparam int unsigned AddrW = 10;

   localparam logic [SubW-1:0]  SubMax   = SubW'((1 << SCALE_LOG2) - 1);
   localparam logic [IdxW-1:0]  IdxMax   = IdxW'(IMG_DIM - 1);
   localparam logic [AddrW-1:0] RowStep  = AddrW'(IMG_DIM);
   localparam logic [11:0]      WinXLo   = 12'(X0);
   localparam logic [11:0]      WinXHi   = 12'(X0 + W - 1);
   localparam logic [11:0]      WinYLo   = 12'(Y0);
   localparam logic [11:0]      WinYHi   = 12'(Y0 + W - 1);
   localparam logic [11:0]      RingXLo  = 12'((X0 > 0) ? X0 - 1 : 0);
   localparam logic [11:0]      RingXHi  = 12'(X0 + W);
   localparam logic [11:0]      RingYLo  = 12'((Y0 > 0) ? Y0 - 1 : 0);
   localparam logic [11:0]      RingYHi  = 12'(Y0 + W);

   logic [11:0] px, py;
   logic        frame_start, act, in_win, on_ring, on_border;
   logic        first_x, last_x, first_pix, last_pix, adv;

   logic [SubW-1:0]  sub_x_q, sub_x_d, sub_y_q, sub_y_d, sub_y_cur;
   logic [IdxW-1:0]  col_q, col_d, row_q, row_d, row_cur;
   logic [AddrW-1:0] row_base_q, row_base_d, row_base_cur;
   logic [AddrW-1:0] mem_raddr_q, mem_raddr_d;
   logic             active_en_q;

   logic [1:0] de_q, win_q, brd_q, last_q;
   logic [7:0] pix1_q, pix2_q;
   logic [7:0] pix_out_q, pix_out_d;
   logic       pix_out_de_q, frame_done_q;

   assign px = {2'b00, pix_x};
   assign py = {2'b00, pix_y};

   // The enable decision for the frame-start pixel itself uses the value being loaded.
   assign frame_start = pix_de && (pix_x == 10'd0) && (pix_y == 10'd0);
   assign act         = frame_start ? ovl_en : active_en_q;

   assign in_win    = pix_de && (px >= WinXLo) && (px <= WinXHi) && (py >= WinYLo) && (py <= WinYHi);
   assign on_ring   = (px >= RingXLo) && (px <= RingXHi) && (py >= RingYLo) && (py <= RingYHi);
   assign on_border = pix_de && !in_win && on_ring;

   assign first_x   = (px == WinXLo);
   assign last_x    = (px == WinXHi);
   assign first_pix = first_x && (py == WinYLo);
   assign last_pix  = last_x && (py == WinYHi);
   assign adv       = act && in_win;

   // First window pixel of a frame realigns the vertical state with no external sync.
   assign sub_y_cur    = first_pix ? '0 : sub_y_q;
   assign row_cur      = first_pix ? '0 : row_q;
   assign row_base_cur = first_pix ? '0 : row_base_q;

   always_comb begin
      sub_x_d     = sub_x_q;
      col_d       = col_q;
      sub_y_d     = sub_y_q;
      row_d       = row_q;
      row_base_d  = row_base_q;
      mem_raddr_d = mem_raddr_q;
      if (adv) begin
         if (first_x) begin
            sub_x_d = '0;
            col_d   = '0;
         end else begin
            sub_x_d = (sub_x_q == SubMax) ? '0 : sub_x_q + 1'b1;
            if ((sub_x_q == SubMax) && (col_q != IdxMax)) begin
               col_d = col_q + 1'b1;
            end
         end
         sub_y_d    = sub_y_cur;
         row_d      = row_cur;
         row_base_d = row_base_cur;
         if (last_x) begin
            sub_y_d = (sub_y_cur == SubMax) ? '0 : sub_y_cur + 1'b1;
            // Row saturation keeps the address inside the 0..IMG_DIM^2-1 range.
            if ((sub_y_cur == SubMax) && (row_cur != IdxMax)) begin
               row_d      = row_cur + 1'b1;
               row_base_d = row_base_cur + RowStep;
            end
         end
         mem_raddr_d = row_base_cur + AddrW'(col_d);
      end
   end

   always_comb begin
      if (!de_q[1]) begin
         pix_out_d = 8'h00;
      end else if (win_q[1]) begin
         pix_out_d = mem_rdata;
      end else if (brd_q[1]) begin
         pix_out_d = BORDER_GRAY;
      end else begin
         pix_out_d = pix2_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_en_q  <= 1'b0;
         sub_x_q      <= '0;
         col_q        <= '0;
         sub_y_q      <= '0;
         row_q        <= '0;
         row_base_q   <= '0;
         mem_raddr_q  <= '0;
         de_q         <= '0;
         win_q        <= '0;
         brd_q        <= '0;
         last_q       <= '0;
         pix1_q       <= '0;
         pix2_q       <= '0;
         pix_out_q    <= '0;
         pix_out_de_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         active_en_q  <= act;
         sub_x_q      <= sub_x_d;
         col_q        <= col_d;
         sub_y_q      <= sub_y_d;
         row_q        <= row_d;
         row_base_q   <= row_base_d;
         mem_raddr_q  <= mem_raddr_d;
         de_q         <= {de_q[0], pix_de};
         win_q        <= {win_q[0], adv};
         brd_q        <= {brd_q[0], act && on_border};
         last_q       <= {last_q[0], adv && last_pix};
         pix1_q       <= pix_in;
         pix2_q       <= pix1_q;
         pix_out_q    <= pix_out_d;
         pix_out_de_q <= de_q[1];
         frame_done_q <= last_q[1];
      end
   end

   assign mem_raddr  = mem_raddr_q;
   assign pix_out    = pix_out_q;
   assign pix_out_de = pix_out_de_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_image_overlay_reader.sv
// Directed bench for image_overlay_reader: sparse VGA-like pixel streams with hand-computed results.
// Image memory holds addr[7:0] at every address.
module tb_image_overlay_reader;

   localparam int X0 = 400;
   localparam int Y0 = 16;
   localparam int W  = 224;

   logic       clk = 1'b0;
   logic       rst;
   logic       ovl_en;
   logic       pix_de;
   logic [9:0] pix_x, pix_y;
   logic [7:0] pix_in;
   logic [9:0] mem_raddr;
   logic [7:0] mem_rdata;
   logic [7:0] pix_out;
   logic       pix_out_de;
   logic       frame_done;

   int n_cmp  = 0;
   int n_bad  = 0;
   int fd_cnt = 0;

   image_overlay_reader dut (
      .clk        (clk),
      .rst        (rst),
      .ovl_en     (ovl_en),
      .pix_de     (pix_de),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_in     (pix_in),
      .mem_raddr  (mem_raddr),
      .mem_rdata  (mem_rdata),
      .pix_out    (pix_out),
      .pix_out_de (pix_out_de),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_rdata <= mem_raddr[7:0];

   always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

   // One pixel per clock; returns 1 time unit after the edge that sampled it.
   task automatic drive(input int x, input int y, input logic de, input logic [7:0] pin);
      pix_x  = 10'(x);
      pix_y  = 10'(y);
      pix_de = de;
      pix_in = pin;
      @(posedge clk);
      #1;
   endtask

   // Only the last window pixel of each line: enough to step the vertical counters.
   task automatic skip_lines(input int ya, input int yb);
      for (int y = ya; y <= yb; y++) drive(X0 + W - 1, y, 1'b1, 8'h11);
   endtask

   task automatic flush();
      for (int i = 0; i < 3; i++) drive(0, 479, 1'b0, 8'h00);
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      ovl_en = 1'b1;
      drive(X0, Y0, 1'b1, 8'h77);
      drive(X0 + 1, Y0, 1'b1, 8'h77);
      drive(0, 0, 1'b1, 8'h77);
      n_cmp++;
      if (mem_raddr !== 10'd0) begin
         n_bad++; $display("FAIL reset_raddr: got %0d want 0", mem_raddr);
      end
      n_cmp++;
      if (pix_out !== 8'h00) begin
         n_bad++; $display("FAIL reset_pix_out: got %h want 00", pix_out);
      end
      n_cmp++;
      if (pix_out_de !== 1'b0) begin
         n_bad++; $display("FAIL reset_pix_out_de: got %b want 0", pix_out_de);
      end
      n_cmp++;
      if (frame_done !== 1'b0) begin
         n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done);
      end
      rst    = 1'b0;
      ovl_en = 1'b0;
   endtask

   task automatic test_latency();
      drive(0, 100, 1'b1, 8'h01);
      drive(1, 100, 1'b1, 8'h02);
      drive(2, 100, 1'b1, 8'hA5);
      drive(3, 100, 1'b0, 8'hEE);
      n_cmp++;
      if (pix_out !== 8'h02) begin
         n_bad++; $display("FAIL latency_not_early: got %h want 02", pix_out);
      end
      drive(4, 100, 1'b1, 8'h33);
      n_cmp++;
      if (pix_out !== 8'hA5 || pix_out_de !== 1'b1) begin
         n_bad++; $display("FAIL latency_pass: got %h/%b want a5/1", pix_out, pix_out_de);
      end
      drive(5, 100, 1'b1, 8'h44);
      n_cmp++;
      if (pix_out !== 8'h00 || pix_out_de !== 1'b0) begin
         n_bad++; $display("FAIL latency_de0: got %h/%b want 00/0", pix_out, pix_out_de);
      end
      drive(6, 100, 1'b1, 8'h55);
      n_cmp++;
      if (pix_out !== 8'h33) begin
         n_bad++; $display("FAIL latency_next: got %h want 33", pix_out);
      end
   endtask

   task automatic test_overlay();
      int fd0;
      fd0    = fd_cnt;
      ovl_en = 1'b1;
      drive(0, 0, 1'b1, 8'h00);
      drive(X0 + W, Y0 - 1, 1'b1, 8'h22);
      drive(X0 + W + 1, Y0 - 1, 1'b1, 8'h33);
      drive(X0 + W + 2, Y0 - 1, 1'b1, 8'h44);
      n_cmp++;
      if (pix_out !== 8'hFF) begin
         n_bad++; $display("FAIL border_top_right: got %h want ff", pix_out);
      end
      drive(X0 + W + 3, Y0 - 1, 1'b1, 8'h44);
      n_cmp++;
      if (pix_out !== 8'h33) begin
         n_bad++; $display("FAIL outside_ring: got %h want 33", pix_out);
      end
      drive(X0 - 2, Y0, 1'b1, 8'h3C);
      drive(X0 - 1, Y0, 1'b1, 8'h11);
      drive(X0, Y0, 1'b1, 8'h11);
      n_cmp++;
      if (mem_raddr !== 10'd0) begin
         n_bad++; $display("FAIL first_addr: got %0d want 0", mem_raddr);
      end
      n_cmp++;
      if (pix_out !== 8'h3C) begin
         n_bad++; $display("FAIL left_of_ring: got %h want 3c", pix_out);
      end
      for (int x = X0 + 1; x <= X0 + W - 1; x++) drive(x, Y0, 1'b1, 8'h11);
      skip_lines(Y0 + 1, Y0 + 9);
      drive(X0 - 1, Y0 + 10, 1'b1, 8'h12);
      drive(X0, Y0 + 10, 1'b1, 8'h11);
      drive(X0 + W - 1, Y0 + 10, 1'b1, 8'h11);
      n_cmp++;
      if (pix_out !== 8'hFF) begin
         n_bad++; $display("FAIL border_left: got %h want ff", pix_out);
      end
      skip_lines(Y0 + 11, Y0 + 22);
      for (int x = X0; x <= X0 + W - 1; x++) begin
         drive(x, Y0 + 23, 1'b1, 8'h11);
         if (x == X0 + 43) begin
            n_cmp++;
            if (mem_raddr !== 10'd61) begin
               n_bad++; $display("FAIL mid_addr: got %0d want 61", mem_raddr);
            end
         end
         if (x == X0 + 45) begin
            n_cmp++;
            if (pix_out !== 8'd61) begin
               n_bad++; $display("FAIL mid_pixel: got %0d want 61", pix_out);
            end
         end
      end
      skip_lines(Y0 + 24, Y0 + 99);
      drive(X0, Y0 + 100, 1'b0, 8'h11);
      drive(X0 + 1, Y0 + 100, 1'b1, 8'h11);
      drive(X0 + 2, Y0 + 100, 1'b1, 8'h11);
      n_cmp++;
      if (pix_out !== 8'h00 || pix_out_de !== 1'b0) begin
         n_bad++; $display("FAIL win_de0: got %h/%b want 00/0", pix_out, pix_out_de);
      end
      skip_lines(Y0 + 100, Y0 + W - 2);
      for (int x = X0; x <= X0 + W - 1; x++) begin
         drive(x, Y0 + W - 1, 1'b1, 8'h11);
         if (x == X0 + W - 1) begin
            n_cmp++;
            if (mem_raddr !== 10'd783) begin
               n_bad++; $display("FAIL last_addr: got %0d want 783", mem_raddr);
            end
         end
      end
      drive(X0 + W, Y0 + W - 1, 1'b1, 8'h11);
      n_cmp++;
      if (frame_done !== 1'b0) begin
         n_bad++; $display("FAIL frame_done_early: got %b want 0", frame_done);
      end
      drive(X0 + W + 1, Y0 + W - 1, 1'b1, 8'h11);
      n_cmp++;
      if (frame_done !== 1'b1 || pix_out !== 8'd15) begin
         n_bad++; $display("FAIL frame_done_pulse: got %b/%0d want 1/15", frame_done, pix_out);
      end
      drive(X0 + W + 2, Y0 + W - 1, 1'b1, 8'h11);
      n_cmp++;
      if (frame_done !== 1'b0 || pix_out !== 8'hFF) begin
         n_bad++; $display("FAIL frame_done_end: got %b/%h want 0/ff", frame_done, pix_out);
      end
      drive(X0 + 5, Y0 + W, 1'b1, 8'h11);
      drive(X0 + 6, Y0 + W, 1'b1, 8'h11);
      drive(X0 + 7, Y0 + W, 1'b1, 8'h11);
      n_cmp++;
      if (pix_out !== 8'hFF) begin
         n_bad++; $display("FAIL border_bottom: got %h want ff", pix_out);
      end
      flush();
      n_cmp++;
      if (fd_cnt - fd0 !== 1) begin
         n_bad++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt - fd0);
      end
   endtask

   task automatic test_gating_rise();
      int fd0;
      fd0    = fd_cnt;
      ovl_en = 1'b0;
      drive(0, 0, 1'b1, 8'h00);
      drive(X0, Y0, 1'b1, 8'h5A);
      drive(X0 + 1, Y0, 1'b1, 8'h11);
      drive(X0 + 2, Y0, 1'b1, 8'h11);
      n_cmp++;
      if (pix_out !== 8'h5A) begin
         n_bad++; $display("FAIL gate_off_win: got %h want 5a", pix_out);
      end
      skip_lines(Y0, 199);
      ovl_en = 1'b1;
      drive(X0 + 10, 200, 1'b1, 8'h6B);
      drive(X0 + 11, 200, 1'b1, 8'h11);
      drive(X0 + 12, 200, 1'b1, 8'h11);
      n_cmp++;
      if (pix_out !== 8'h6B) begin
         n_bad++; $display("FAIL gate_rise_midframe: got %h want 6b", pix_out);
      end
      skip_lines(200, Y0 + W - 1);
      drive(X0 + W, Y0 + W - 1, 1'b1, 8'h4E);
      drive(X0 + W + 1, Y0 + W - 1, 1'b1, 8'h11);
      drive(X0 + W + 2, Y0 + W - 1, 1'b1, 8'h11);
      n_cmp++;
      if (pix_out !== 8'h4E) begin
         n_bad++; $display("FAIL gate_no_border: got %h want 4e", pix_out);
      end
      flush();
      n_cmp++;
      if (fd_cnt !== fd0) begin
         n_bad++; $display("FAIL gate_no_frame_done: got %0d want %0d", fd_cnt, fd0);
      end
   endtask

   task automatic test_gating_fall();
      int fd0;
      fd0 = fd_cnt;
      drive(0, 0, 1'b1, 8'h00);
      drive(X0, Y0, 1'b1, 8'h11);
      n_cmp++;
      if (mem_raddr !== 10'd0) begin
         n_bad++; $display("FAIL fall_first_addr: got %0d want 0", mem_raddr);
      end
      skip_lines(Y0, Y0 + 4);
      ovl_en = 1'b0;
      skip_lines(Y0 + 5, Y0 + 99);
      drive(X0, Y0 + 100, 1'b1, 8'h11);
      n_cmp++;
      if (mem_raddr !== 10'd336) begin
         n_bad++; $display("FAIL fall_addr: got %0d want 336", mem_raddr);
      end
      drive(X0 + 1, Y0 + 100, 1'b1, 8'h11);
      drive(X0 + 2, Y0 + 100, 1'b1, 8'h11);
      n_cmp++;
      if (pix_out !== 8'd80) begin
         n_bad++; $display("FAIL fall_pixel: got %0d want 80", pix_out);
      end
      skip_lines(Y0 + 100, Y0 + W - 1);
      flush();
      n_cmp++;
      if (fd_cnt - fd0 !== 1) begin
         n_bad++; $display("FAIL fall_frame_done: got %0d want 1", fd_cnt - fd0);
      end
   endtask

   task automatic test_reset_mid();
      int fd0;
      ovl_en = 1'b1;
      drive(0, 0, 1'b1, 8'h00);
      drive(X0, Y0, 1'b1, 8'h11);
      skip_lines(Y0, Y0 + 59);
      rst = 1'b1;
      drive(X0 + 50, Y0 + 60, 1'b1, 8'h11);
      n_cmp++;
      if (mem_raddr !== 10'd0 || pix_out !== 8'h00) begin
         n_bad++; $display("FAIL midrst_data: got %0d/%h want 0/00", mem_raddr, pix_out);
      end
      n_cmp++;
      if (pix_out_de !== 1'b0 || frame_done !== 1'b0) begin
         n_bad++; $display("FAIL midrst_flags: got %b/%b want 0/0", pix_out_de, frame_done);
      end
      rst = 1'b0;
      fd0 = fd_cnt;
      drive(X0 + 51, Y0 + 60, 1'b1, 8'h11);
      skip_lines(Y0 + 60, Y0 + 99);
      drive(X0, Y0 + 100, 1'b1, 8'h5A);
      drive(X0 + 1, Y0 + 100, 1'b1, 8'h11);
      drive(X0 + 2, Y0 + 100, 1'b1, 8'h11);
      n_cmp++;
      if (pix_out !== 8'h5A) begin
         n_bad++; $display("FAIL midrst_passthrough: got %h want 5a", pix_out);
      end
      skip_lines(Y0 + 100, Y0 + W - 1);
      flush();
      n_cmp++;
      if (fd_cnt !== fd0) begin
         n_bad++; $display("FAIL midrst_frame_done: got %0d want %0d", fd_cnt, fd0);
      end
   endtask

   initial begin
      rst    = 1'b1;
      ovl_en = 1'b0;
      pix_de = 1'b0;
      pix_x  = '0;
      pix_y  = '0;
      pix_in = '0;
      test_reset();
      test_latency();
      test_overlay();
      test_overlay();
      test_gating_rise();
      test_gating_fall();
      test_reset_mid();
      test_overlay();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
